// File: rtl/mpe_tile_sequencer_if.sv
// rtl/mpe_tile_sequencer_if.sv - config, pixel and window bundle of the MPE tile sequencer
interface mpe_tile_sequencer_if #(
    parameter int BIN_LEN       = 8,
    parameter int INPUT_HEIGHT  = 4,
    parameter int INPUT_WIDTH   = 4,
    parameter int KERNEL_HEIGHT = 2,
    parameter int KERNEL_WIDTH  = 2
);
    localparam int KHC_W = $clog2(KERNEL_HEIGHT + 1);
    localparam int KWC_W = $clog2(KERNEL_WIDTH + 1);
    localparam int WH_W  = $clog2(KERNEL_HEIGHT);
    localparam int WW_W  = $clog2(KERNEL_WIDTH);

    logic                                                 cfg_valid;
    logic                                                 cfg_ready;
    logic [KHC_W-1:0]                                     cfg_kh;
    logic [KWC_W-1:0]                                     cfg_kw;
    logic [2:0]                                           cfg_stride;
    logic                                                 px_valid;
    logic                                                 px_ready;
    logic [BIN_LEN-1:0]                                   px_data;
    logic [INPUT_HEIGHT-1:0][INPUT_WIDTH-1:0][BIN_LEN-1:0] in_vals;
    logic [WH_W-1:0]                                      weight_height;
    logic [WW_W-1:0]                                      weight_width;
    logic [2:0]                                           stride;
    logic                                                 win_valid;
    logic                                                 win_ready;
    logic                                                 win_first;
    logic                                                 win_last;
    logic                                                 done;

    modport master (
        input  cfg_valid, cfg_kh, cfg_kw, cfg_stride, px_valid, px_data, win_ready,
        output cfg_ready, px_ready, in_vals, weight_height, weight_width, stride,
               win_valid, win_first, win_last, done
    );

    modport slave (
        output cfg_valid, cfg_kh, cfg_kw, cfg_stride, px_valid, px_data, win_ready,
        input  cfg_ready, px_ready, in_vals, weight_height, weight_width, stride,
               win_valid, win_first, win_last, done
    );
endinterface

// File: rtl/mpe_tile_sequencer.sv
// rtl/mpe_tile_sequencer.sv - loads one activation tile, then sweeps every kernel offset over it
module mpe_tile_sequencer #(
    parameter int BIN_LEN       = 8,
    parameter int INPUT_HEIGHT  = 4,
    parameter int INPUT_WIDTH   = 4,
    parameter int KERNEL_HEIGHT = 2,
    parameter int KERNEL_WIDTH  = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    mpe_tile_sequencer_if.master bus_if
);
    localparam int KHC_W = $clog2(KERNEL_HEIGHT + 1);
    localparam int KWC_W = $clog2(KERNEL_WIDTH + 1);
    localparam int WH_W  = $clog2(KERNEL_HEIGHT);
    localparam int WW_W  = $clog2(KERNEL_WIDTH);
    localparam int ROW_W = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
    localparam int COL_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t                                                state_q;
    logic [INPUT_HEIGHT-1:0][INPUT_WIDTH-1:0][BIN_LEN-1:0] buf_q;
    logic [ROW_W-1:0]                                      row_q;
    logic [COL_W-1:0]                                      col_q;
    logic [KHC_W-1:0]                                      kh_q, kh_d;
    logic [KWC_W-1:0]                                      kw_q, kw_d;
    logic [2:0]                                            stride_q, stride_d;
    logic [WH_W-1:0]                                       wh_q;
    logic [WW_W-1:0]                                       ww_q;
    logic                                                  done_q;
    logic                                                  wh_end, ww_end;

    // Out-of-range kernel sizes and a zero stride are folded into the nearest legal value.
    always_comb begin
        kh_d = bus_if.cfg_kh;
        if (bus_if.cfg_kh == '0)
            kh_d = KHC_W'(1);
        else if (bus_if.cfg_kh > KHC_W'(KERNEL_HEIGHT))
            kh_d = KHC_W'(KERNEL_HEIGHT);
        kw_d = bus_if.cfg_kw;
        if (bus_if.cfg_kw == '0)
            kw_d = KWC_W'(1);
        else if (bus_if.cfg_kw > KWC_W'(KERNEL_WIDTH))
            kw_d = KWC_W'(KERNEL_WIDTH);
        stride_d = (bus_if.cfg_stride == 3'd0) ? 3'd1 : bus_if.cfg_stride;
    end

    assign wh_end = (KHC_W'(wh_q) == kh_q - KHC_W'(1));
    assign ww_end = (KWC_W'(ww_q) == kw_q - KWC_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            kh_q     <= '0;
            kw_q     <= '0;
            stride_q <= '0;
            wh_q     <= '0;
            ww_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.cfg_valid) begin
                        kh_q     <= kh_d;
                        kw_q     <= kw_d;
                        stride_q <= stride_d;
                        row_q    <= '0;
                        col_q    <= '0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus_if.px_valid) begin
                        buf_q[row_q][col_q] <= bus_if.px_data;
                        if (col_q == COL_W'(INPUT_WIDTH - 1)) begin
                            col_q <= '0;
                            if (row_q == ROW_W'(INPUT_HEIGHT - 1)) begin
                                row_q   <= '0;
                                wh_q    <= '0;
                                ww_q    <= '0;
                                state_q <= SWEEP;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (bus_if.win_ready) begin
                        if (ww_end) begin
                            ww_q <= '0;
                            if (wh_end) begin
                                wh_q    <= '0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                wh_q <= wh_q + WH_W'(1);
                            end
                        end else begin
                            ww_q <= ww_q + WW_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.cfg_ready     = (state_q == IDLE);
    assign bus_if.px_ready      = (state_q == LOAD);
    assign bus_if.win_valid     = (state_q == SWEEP);
    assign bus_if.win_first     = bus_if.win_valid && (wh_q == '0) && (ww_q == '0);
    assign bus_if.win_last      = bus_if.win_valid && wh_end && ww_end;
    assign bus_if.in_vals       = buf_q;
    assign bus_if.weight_height = wh_q;
    assign bus_if.weight_width  = ww_q;
    assign bus_if.stride        = stride_q;
    assign bus_if.done          = done_q;
endmodule

// File: tb/tb_mpe_tile_sequencer.sv
// tb/tb_mpe_tile_sequencer.sv - randomized self-checking bench for mpe_tile_sequencer
module tb_mpe_tile_sequencer;
    localparam int BL = 8;
    localparam int IH = 4;
    localparam int IW = 4;
    localparam int KH = 2;
    localparam int KW = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [BL-1:0] exp_tile [IH][IW];
    bit   win_pat [7] = '{0, 1, 0, 0, 1, 1, 1};

    mpe_tile_sequencer_if #(.BIN_LEN(BL), .INPUT_HEIGHT(IH), .INPUT_WIDTH(IW),
                            .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW)) bus ();

    mpe_tile_sequencer #(.BIN_LEN(BL), .INPUT_HEIGHT(IH), .INPUT_WIDTH(IW),
                         .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_tile(input string tag);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c), bus.in_vals[r][c], exp_tile[r][c]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_px_ready"}, bus.px_ready, 0);
        chk({tag, "_win_valid"}, bus.win_valid, 0);
        chk({tag, "_win_first"}, bus.win_first, 0);
        chk({tag, "_win_last"}, bus.win_last, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_stride"}, bus.stride, 0);
        chk({tag, "_wh"}, bus.weight_height, 0);
        chk({tag, "_ww"}, bus.weight_width, 0);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                exp_tile[r][c] = '0;
        chk_tile({tag, "_tile"});
    endtask

    // Called at posedge+1; reset rises mid-cycle and is checked before any clock edge.
    task automatic async_reset_check(input string tag);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs(tag);
        bus.cfg_valid = 1'b1;
        bus.cfg_kh    = 2'd2;
        bus.cfg_kw    = 2'd2;
        tick();
        chk({tag, "_no_cfg_in_reset"}, bus.px_ready, 0);
        chk({tag, "_no_done"}, bus.done, 0);
        bus.cfg_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic run_tile(input int kh_in, input int kw_in, input int st_in,
                            input logic [BL-1:0] base, input int px_mode,
                            input int win_mode, input bit ign);
        int ekh, ekw, est, n, cyc;
        bit take;
        int q_h[$];
        int q_w[$];
        logic [BL-1:0] pv;
        ekh = (kh_in == 0) ? 1 : ((kh_in > KH) ? KH : kh_in);
        ekw = (kw_in == 0) ? 1 : ((kw_in > KW) ? KW : kw_in);
        est = (st_in == 0) ? 1 : st_in;
        for (int h = 0; h < ekh; h++)
            for (int w = 0; w < ekw; w++) begin
                q_h.push_back(h);
                q_w.push_back(w);
            end

        bus.cfg_valid  = 1'b1;
        bus.cfg_kh     = 2'(kh_in);
        bus.cfg_kw     = 2'(kw_in);
        bus.cfg_stride = 3'(st_in);
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        tick();
        bus.cfg_valid = 1'b0;
        chk("done_cleared", bus.done, 0);
        chk("px_ready_after_cfg", bus.px_ready, 1);
        chk("cfg_ready_in_load", bus.cfg_ready, 0);
        chk("stride_captured", bus.stride, est);

        n = 0;
        cyc = 0;
        while (n < IH * IW) begin
            if (cyc > 300) begin
                chk("load_timeout", 0, 1);
                return;
            end
            case (px_mode)
                0: bus.px_valid = 1'b1;
                1: bus.px_valid = (cyc % 2 == 0);
                default: bus.px_valid = 1'($urandom_range(0, 1));
            endcase
            pv = BL'(int'(base) + n);
            bus.px_data = bus.px_valid ? pv : 8'hee;
            take = bus.px_valid && bus.px_ready;
            tick();
            cyc++;
            if (take) begin
                exp_tile[n / IW][n % IW] = pv;
                chk("pixel_visible", bus.in_vals[n / IW][n % IW], pv);
                n++;
            end
            if (n < IH * IW) chk("no_window_in_load", bus.win_valid, 0);
        end
        if (px_mode == 0) chk("load_length", cyc, IH * IW);
        chk_tile("tile_loaded");

        bus.px_valid   = ign;
        bus.px_data    = 8'haa;
        bus.cfg_valid  = ign;
        bus.cfg_kh     = 2'd1;
        bus.cfg_kw     = 2'd1;
        bus.cfg_stride = 3'd5;

        cyc = 0;
        while (q_h.size() > 0) begin
            if (cyc > 300) begin
                chk("sweep_timeout", 0, 1);
                return;
            end
            chk("win_valid", bus.win_valid, 1);
            chk("cfg_ready_in_sweep", bus.cfg_ready, 0);
            chk("px_ready_in_sweep", bus.px_ready, 0);
            chk("weight_height", bus.weight_height, q_h[0]);
            chk("weight_width", bus.weight_width, q_w[0]);
            chk("win_first", bus.win_first, (q_h[0] == 0) && (q_w[0] == 0));
            chk("win_last", bus.win_last, q_h.size() == 1);
            chk("stride_hold", bus.stride, est);
            chk("done_in_sweep", bus.done, 0);
            case (win_mode)
                0: bus.win_ready = 1'b1;
                1: bus.win_ready = (cyc < 7) ? win_pat[cyc] : 1'b1;
                default: bus.win_ready = 1'($urandom_range(0, 1));
            endcase
            take = bus.win_ready;
            tick();
            cyc++;
            if (take) begin
                void'(q_h.pop_front());
                void'(q_w.pop_front());
            end
        end
        bus.win_ready = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.px_valid  = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("cfg_ready_at_done", bus.cfg_ready, 1);
        chk("win_valid_after_sweep", bus.win_valid, 0);
        chk("win_last_after_sweep", bus.win_last, 0);
        if (win_mode == 0) chk("sweep_length", cyc, ekh * ekw);
        chk_tile("tile_retained");
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.cfg_valid  = 1'b0;
        bus.cfg_kh     = '0;
        bus.cfg_kw     = '0;
        bus.cfg_stride = '0;
        bus.px_valid   = 1'b0;
        bus.px_data    = '0;
        bus.win_ready  = 1'b0;
        #2;
        chk_reset_outputs("por");
        tick();
        rst = 1'b0;

        run_tile(2, 2, 1, 8'd1, 0, 0, 1'b0);
        async_reset_check("rst_after_pass");
        run_tile(2, 2, 1, 8'd1, 1, 1, 1'b0);
        run_tile(0, 3, 0, 8'd50, 0, 0, 1'b0);

        bus.cfg_valid  = 1'b1;
        bus.cfg_kh     = 2'd2;
        bus.cfg_kw     = 2'd2;
        bus.cfg_stride = 3'd1;
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.px_valid = 1'b1;
            bus.px_data  = 8'(k + 100);
            tick();
        end
        bus.px_valid = 1'b0;
        async_reset_check("rst_mid_load");
        run_tile(2, 2, 1, 8'd17, 0, 0, 1'b0);

        run_tile(2, 2, 3, 8'd100, 0, 0, 1'b1);

        for (int i = 0; i < 8; i++)
            run_tile($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                     8'($urandom), $urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? 2 : 0,
                     1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
